// File: rtl/csrhgei.sv
// csrhgei: guest-external-interrupt unit for the hypervisor CSR space.
// Owns hgeip (0xE12, read-only) and hgeie (0x607). It synchronises GEILEN
// guest interrupt lines, captures each one as level or edge, and drives
// mip.SGEIP and the VGEIN-selected hip.VSEIP contribution.
// The XLEN / M_MODE / S_MODE fields of the core configuration are passed in
// as scalar parameters so this block elaborates without the config package.
module csrhgei #(
    parameter int                XLEN        = 64,
    parameter logic [1:0]        M_MODE      = 2'b11,
    parameter logic [1:0]        S_MODE      = 2'b01,
    parameter int                GEILEN      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [GEILEN-1:0] EDGE_MASK   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GEILEN-1:0] GEIRawM,
    input  logic              CSRHWriteM,
    input  logic [11:0]       CSRAdrM,
    input  logic [XLEN-1:0]   CSRWriteValM,
    input  logic [1:0]        PrivilegeModeW,
    input  logic              VirtModeW,
    input  logic [5:0]        VGEIN,
    input  logic              GEIClaimM,
    output logic [XLEN-1:0]   CSRHGEIReadValM,
    output logic              CSRHGEIHitM,
    output logic              IllegalCSRHGEIAccessM,
    output logic              SGEIPM,
    output logic              VSEIPGuestM
);

    localparam logic [11:0] ADR_HGEIE = 12'h607;
    localparam logic [11:0] ADR_HGEIP = 12'hE12;

    // Mask of the implemented hgeie/hgeip bits [GEILEN:1].
    function automatic logic [XLEN-1:0] impl_mask();
        logic [XLEN-1:0] m;
        m = '0;
        for (int b = 1; b <= GEILEN; b++) m[b] = 1'b1;
        return m;
    endfunction
    localparam logic [XLEN-1:0] IMPL_MASK = impl_mask();

    logic [GEILEN:1] r_hgeie;
    logic [GEILEN:1] w_hgeip;
    logic            w_hit_hgeie;
    logic            w_hit_hgeip;
    logic            w_legal;
    logic            w_we_hgeie;
    logic [XLEN-1:0] w_hgeie_x;
    logic [XLEN-1:0] w_hgeip_x;
    logic            w_unused_wdata;

    // ------------------------------------------------------------------
    // Address decode and access legality
    // ------------------------------------------------------------------
    assign w_hit_hgeie = (CSRAdrM == ADR_HGEIE);
    assign w_hit_hgeip = (CSRAdrM == ADR_HGEIP);
    assign CSRHGEIHitM = w_hit_hgeie | w_hit_hgeip;

    // Only M-mode and HS-mode (S with V=0) may touch these registers.
    assign w_legal = (PrivilegeModeW == M_MODE) |
                     ((PrivilegeModeW == S_MODE) & ~VirtModeW);

    // hgeip is read-only, so any write to it is illegal even from M-mode.
    assign IllegalCSRHGEIAccessM = CSRHGEIHitM &
                                   (~w_legal | (CSRHWriteM & w_hit_hgeip));

    assign w_we_hgeie = CSRHWriteM & w_legal & w_hit_hgeie;

    // Write data outside [GEILEN:1] is deliberately ignored.
    assign w_unused_wdata = ^(CSRWriteValM & ~IMPL_MASK);

    // ------------------------------------------------------------------
    // hgeie enable register
    // ------------------------------------------------------------------
    // Register the writable enable bits; bit 0 and upper bits stay zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hgeie <= '0;
        end else if (w_we_hgeie) begin
            r_hgeie <= CSRWriteValM[GEILEN:1];
        end
    end

    // ------------------------------------------------------------------
    // Per-channel synchroniser and pending capture
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi <= GEILEN; gi++) begin : g_ch
            localparam bit IS_EDGE = EDGE_MASK[gi-1];

            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic                   r_pend;
            logic                   w_sync;
            logic                   w_rise;
            logic                   w_clr;

            // Shift the asynchronous line through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= GEIRawM[gi-1];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];
            assign w_rise = w_sync & ~r_prev;
            assign w_clr  = GEIClaimM & (VGEIN == 6'(gi));

            // Track the previous synchronised value and update the pending bit;
            // for edge channels a new rising edge wins over a simultaneous claim.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_prev <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    r_prev <= w_sync;
                    if (IS_EDGE) begin
                        r_pend <= w_rise | (r_pend & ~w_clr);
                    end else begin
                        r_pend <= w_sync;
                    end
                end
            end

            assign w_hgeip[gi] = r_pend;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Interrupt outputs
    // ------------------------------------------------------------------
    assign SGEIPM = |(w_hgeip & r_hgeie);

    // Select the pending bit of the guest named by VGEIN; out-of-range is 0.
    always_comb begin
        VSEIPGuestM = 1'b0;
        for (int c = 1; c <= GEILEN; c++) begin
            if (VGEIN == 6'(c)) VSEIPGuestM = w_hgeip[c];
        end
    end

    // ------------------------------------------------------------------
    // CSR read mux
    // ------------------------------------------------------------------
    // Zero-extend the registers into XLEN and gate read data on a legal hit.
    always_comb begin
        w_hgeie_x           = '0;
        w_hgeip_x           = '0;
        w_hgeie_x[GEILEN:1] = r_hgeie;
        w_hgeip_x[GEILEN:1] = w_hgeip;
        CSRHGEIReadValM     = '0;
        if (!IllegalCSRHGEIAccessM) begin
            if (w_hit_hgeie)      CSRHGEIReadValM = w_hgeie_x;
            else if (w_hit_hgeip) CSRHGEIReadValM = w_hgeip_x;
        end
    end

endmodule

// File: tb/tb_csrhgei.sv
// tb_csrhgei: directed bench for csrhgei with GEILEN=4, SYNC_STAGES=2,
// channels 1, 2 and 4 edge-captured and channel 3 level-captured.
// Inputs change 1ns after the rising edge; outputs are sampled a few ns later.
`timescale 1ns/100ps
module tb_csrhgei;

    localparam int          XLEN   = 32;
    localparam int          GEILEN = 4;
    localparam int          SYNC   = 2;
    localparam logic [3:0]  EMASK  = 4'b1011;
    localparam logic [11:0] A_IE   = 12'h607;
    localparam logic [11:0] A_IP   = 12'hE12;

    logic              clk = 1'b0;
    logic              reset;
    logic [GEILEN-1:0] GEIRawM;
    logic              CSRHWriteM;
    logic [11:0]       CSRAdrM;
    logic [XLEN-1:0]   CSRWriteValM;
    logic [1:0]        PrivilegeModeW;
    logic              VirtModeW;
    logic [5:0]        VGEIN;
    logic              GEIClaimM;
    logic [XLEN-1:0]   CSRHGEIReadValM;
    logic              CSRHGEIHitM;
    logic              IllegalCSRHGEIAccessM;
    logic              SGEIPM;
    logic              VSEIPGuestM;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    csrhgei #(
        .XLEN(XLEN), .M_MODE(2'b11), .S_MODE(2'b01),
        .GEILEN(GEILEN), .SYNC_STAGES(SYNC), .EDGE_MASK(EMASK)
    ) dut (
        .clk(clk), .reset(reset), .GEIRawM(GEIRawM),
        .CSRHWriteM(CSRHWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM),
        .PrivilegeModeW(PrivilegeModeW), .VirtModeW(VirtModeW), .VGEIN(VGEIN),
        .GEIClaimM(GEIClaimM), .CSRHGEIReadValM(CSRHGEIReadValM),
        .CSRHGEIHitM(CSRHGEIHitM), .IllegalCSRHGEIAccessM(IllegalCSRHGEIAccessM),
        .SGEIPM(SGEIPM), .VSEIPGuestM(VSEIPGuestM)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        CSRAdrM    = a;
        CSRHWriteM = 1'b0;
        #1;
        chk(tag, CSRHGEIReadValM, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CSRAdrM      = a;
        CSRWriteValM = d;
        CSRHWriteM   = 1'b1;
        cyc(1);
        CSRHWriteM   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; GEIRawM = '0; CSRHWriteM = 1'b0; CSRAdrM = 12'h000;
        CSRWriteValM = '0; PrivilegeModeW = 2'b11; VirtModeW = 1'b0;
        VGEIN = 6'd0; GEIClaimM = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Reset state
        chk("reset_sgeip", 32'(SGEIPM), 32'd0);
        chk("reset_vseip", 32'(VSEIPGuestM), 32'd0);
        chk("reset_nohit_hit", 32'(CSRHGEIHitM), 32'd0);
        chk("reset_nohit_ill", 32'(IllegalCSRHGEIAccessM), 32'd0);
        chk("reset_nohit_val", CSRHGEIReadValM, 32'd0);
        rd(A_IE, 32'h0, "reset_hgeie");
        rd(A_IP, 32'h0, "reset_hgeip");

        // hgeie all-ones write keeps only bits [4:1]
        wr(A_IE, 32'hFFFF_FFFF);
        rd(A_IE, 32'h1E, "hgeie_ones");
        chk("hgeie_ones_sgeip", 32'(SGEIPM), 32'd0);

        // Level channel 3: 3-edge latency on rise and fall, claim ignored
        GEIRawM = 4'b0100;
        cyc(2);
        rd(A_IP, 32'h0, "lvl_lat2");
        cyc(1);
        rd(A_IP, 32'h8, "lvl_lat3");
        chk("lvl_sgeip", 32'(SGEIPM), 32'd1);
        VGEIN = 6'd3; #1;
        chk("lvl_vseip", 32'(VSEIPGuestM), 32'd1);
        GEIClaimM = 1'b1;
        cyc(1);
        GEIClaimM = 1'b0;
        rd(A_IP, 32'h8, "lvl_claim_ignored");
        GEIRawM = 4'b0000;
        cyc(2);
        rd(A_IP, 32'h8, "lvl_fall2");
        cyc(1);
        rd(A_IP, 32'h0, "lvl_fall3");
        chk("lvl_fall_sgeip", 32'(SGEIPM), 32'd0);

        // Edge channel 2: one-cycle pulse, sticky pending, claim clears
        VGEIN = 6'd2;
        GEIRawM = 4'b0010;
        cyc(1);
        GEIRawM = 4'b0000;
        cyc(1);
        chk("edge_lat2", 32'(VSEIPGuestM), 32'd0);
        cyc(1);
        chk("edge_set", 32'(VSEIPGuestM), 32'd1);
        rd(A_IP, 32'h4, "edge_hgeip");
        cyc(3);
        chk("edge_sticky", 32'(VSEIPGuestM), 32'd1);
        GEIClaimM = 1'b1;
        cyc(1);
        GEIClaimM = 1'b0; #1;
        chk("edge_claim", 32'(VSEIPGuestM), 32'd0);
        rd(A_IP, 32'h0, "edge_claim_hgeip");

        // New edge arriving in the same cycle as a claim is kept
        GEIRawM = 4'b0010;
        cyc(1);
        GEIRawM = 4'b0000;
        cyc(2);
        chk("edge_reset2", 32'(VSEIPGuestM), 32'd1);
        GEIRawM = 4'b0010;
        cyc(1);
        GEIRawM = 4'b0000;
        cyc(1);
        GEIClaimM = 1'b1;
        cyc(1);
        GEIClaimM = 1'b0; #1;
        chk("claim_vs_edge", 32'(VSEIPGuestM), 32'd1);
        GEIClaimM = 1'b1;
        cyc(1);
        GEIClaimM = 1'b0; #1;
        chk("claim_again", 32'(VSEIPGuestM), 32'd0);

        // Illegal accesses
        PrivilegeModeW = 2'b01; VirtModeW = 1'b1;
        CSRAdrM = A_IP; #1;
        chk("vs_rd_hgeip_ill", 32'(IllegalCSRHGEIAccessM), 32'd1);
        chk("vs_rd_hgeip_hit", 32'(CSRHGEIHitM), 32'd1);
        CSRAdrM = A_IE; #1;
        chk("vs_rd_hgeie_ill", 32'(IllegalCSRHGEIAccessM), 32'd1);
        chk("vs_rd_hgeie_val", CSRHGEIReadValM, 32'd0);

        PrivilegeModeW = 2'b11; VirtModeW = 1'b0;
        CSRAdrM = A_IP; CSRWriteValM = 32'hFFFF_FFFF; CSRHWriteM = 1'b1; #1;
        chk("m_wr_hgeip_ill", 32'(IllegalCSRHGEIAccessM), 32'd1);
        chk("m_wr_hgeip_val", CSRHGEIReadValM, 32'd0);
        cyc(1);
        CSRHWriteM = 1'b0;
        rd(A_IP, 32'h0, "m_wr_hgeip_nochg");
        rd(A_IE, 32'h1E, "m_wr_hgeip_ie_nochg");

        PrivilegeModeW = 2'b00;
        CSRAdrM = A_IE; CSRWriteValM = 32'h0; CSRHWriteM = 1'b1; #1;
        chk("u_wr_hgeie_ill", 32'(IllegalCSRHGEIAccessM), 32'd1);
        cyc(1);
        CSRHWriteM = 1'b0;
        PrivilegeModeW = 2'b11;
        rd(A_IE, 32'h1E, "u_wr_hgeie_nochg");

        // HS-mode write of hgeie is legal
        PrivilegeModeW = 2'b01; VirtModeW = 1'b0;
        CSRAdrM = A_IE; CSRWriteValM = 32'h0000_000A; CSRHWriteM = 1'b1; #1;
        chk("s_wr_hgeie_ill", 32'(IllegalCSRHGEIAccessM), 32'd0);
        cyc(1);
        CSRHWriteM = 1'b0;
        rd(A_IE, 32'h0A, "s_wr_hgeie");

        // Non-owned address
        PrivilegeModeW = 2'b00;
        CSRAdrM = 12'h600; #1;
        chk("adr600_hit", 32'(CSRHGEIHitM), 32'd0);
        chk("adr600_ill", 32'(IllegalCSRHGEIAccessM), 32'd0);
        PrivilegeModeW = 2'b11;

        // VGEIN bounds with all channels pending
        GEIRawM = 4'b1111;
        cyc(3);
        rd(A_IP, 32'h1E, "all_pend");
        chk("all_pend_sgeip", 32'(SGEIPM), 32'd1);
        VGEIN = 6'd0; #1;
        chk("vgein0_vseip", 32'(VSEIPGuestM), 32'd0);
        VGEIN = 6'd5; #1;
        chk("vgein5_vseip", 32'(VSEIPGuestM), 32'd0);
        GEIClaimM = 1'b1;
        cyc(1);
        VGEIN = 6'd0;
        cyc(1);
        GEIClaimM = 1'b0;
        rd(A_IP, 32'h1E, "bad_claim_nochg");
        VGEIN = 6'd4; #1;
        chk("vgein4_vseip", 32'(VSEIPGuestM), 32'd1);
        VGEIN = 6'd1; #1;
        chk("vgein1_vseip", 32'(VSEIPGuestM), 32'd1);

        // SGEIPM follows hgeie masking the cycle after the write
        wr(A_IE, 32'h0);
        chk("sgeip_masked", 32'(SGEIPM), 32'd0);
        wr(A_IE, 32'h1E);
        chk("sgeip_unmasked", 32'(SGEIPM), 32'd1);

        // Mid-operation reset with inputs still high
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        rd(A_IP, 32'h0, "rst_hgeip");
        rd(A_IE, 32'h0, "rst_hgeie");
        chk("rst_sgeip", 32'(SGEIPM), 32'd0);
        chk("rst_vseip", 32'(VSEIPGuestM), 32'd0);
        cyc(2);
        rd(A_IP, 32'h0, "rst_lat2");
        cyc(1);
        rd(A_IP, 32'h1E, "rst_repend");
        chk("rst_repend_vseip", 32'(VSEIPGuestM), 32'd1);
        chk("rst_repend_sgeip", 32'(SGEIPM), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
